// File: rtl/mult_div_pending_control_if.sv
// Handshake bundle between the pipeline, the pending multdiv control
// and the iterative multiply/divide unit.
interface mult_div_pending_control_if;
    logic [31:0] dxir_i;
    logic [31:0] fdir_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        mw_writes_reg_i;
    logic        unit_rdy_i;
    logic        unit_exception_i;
    logic [31:0] unit_result_i;
    logic        ctrl_mult_o;
    logic        ctrl_div_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic [31:0] pwir_o;
    logic [31:0] pending_result_o;
    logic        mult_or_div_ready_o;
    logic        stall_o;

    modport master (
        output dxir_i, fdir_i, operand_a_i, operand_b_i,
        output mw_writes_reg_i, unit_rdy_i, unit_exception_i,
        output unit_result_i,
        input  ctrl_mult_o, ctrl_div_o, op_a_o, op_b_o, pwir_o,
        input  pending_result_o, mult_or_div_ready_o, stall_o
    );

    modport slave (
        input  dxir_i, fdir_i, operand_a_i, operand_b_i,
        input  mw_writes_reg_i, unit_rdy_i, unit_exception_i,
        input  unit_result_i,
        output ctrl_mult_o, ctrl_div_o, op_a_o, op_b_o, pwir_o,
        output pending_result_o, mult_or_div_ready_o, stall_o
    );
endinterface

// File: rtl/mult_div_pending_control.sv
// Tracks one outstanding mul/div: launches the unit, holds its result
// and instruction until writeback, and raises structural/RAW stalls.
module mult_div_pending_control (
    input logic                         clk_i,
    input logic                         rst_ni,
    mult_div_pending_control_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } state_e;

    state_e      state_q;
    logic [31:0] pwir_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] result_q;
    logic [5:0]  cnt_q;
    logic        kind_div_q;
    logic        ctrl_mult_q;
    logic        ctrl_div_q;

    logic [4:0]  dx_op;
    logic [4:0]  dx_alu;
    logic        is_mul;
    logic        is_div;
    logic        start_req;
    logic        start;
    logic        ready;
    logic        struct_stall;
    logic        raw_stall;
    logic        stall;
    logic [4:0]  pw_rd;
    logic [4:0]  fd_op;
    logic [4:0]  fd_rd;
    logic [4:0]  fd_rs;
    logic [4:0]  fd_rt;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic        use_a;
    logic        use_b;
    logic        raw_hit;
    logic [31:0] exc_result;
    logic        unused_fdir;

    assign dx_op  = bus.dxir_i[31:27];
    assign dx_alu = bus.dxir_i[6:2];
    assign is_mul = (dx_op == 5'b00000) && (dx_alu == 5'b00110);
    assign is_div = (dx_op == 5'b00000) && (dx_alu == 5'b00111);
    assign start_req = is_mul || is_div;

    assign ready = (state_q == DONE) && !bus.mw_writes_reg_i;

    assign struct_stall = start_req &&
        ((state_q == START) || (state_q == BUSY) ||
         ((state_q == DONE) && !ready));

    assign pw_rd = pwir_q[26:22];
    assign fd_op = bus.fdir_i[31:27];
    assign fd_rd = bus.fdir_i[26:22];
    assign fd_rs = bus.fdir_i[21:17];
    assign fd_rt = bus.fdir_i[16:12];
    assign unused_fdir = ^bus.fdir_i[11:0];

    always_comb begin
        rd_a  = 5'd0;
        rd_b  = 5'd0;
        use_a = 1'b0;
        use_b = 1'b0;
        unique case (1'b1)
            (fd_op == 5'b00000): begin
                rd_a  = fd_rs;
                rd_b  = fd_rt;
                use_a = 1'b1;
                use_b = 1'b1;
            end
            (fd_op == 5'b00010) || (fd_op == 5'b00110): begin
                rd_a  = fd_rd;
                rd_b  = fd_rs;
                use_a = 1'b1;
                use_b = 1'b1;
            end
            (fd_op == 5'b00111) || (fd_op == 5'b01000): begin
                rd_a  = fd_rd;
                use_a = 1'b1;
            end
            default: ;
        endcase
    end

    assign raw_hit = (use_a && (rd_a == pw_rd)) ||
                     (use_b && (rd_b == pw_rd));

    // The writeback cycle forwards the value, so the hazard is gone then.
    assign raw_stall = (state_q != IDLE) && (pw_rd != 5'd0) &&
                       raw_hit && !ready;

    assign stall = struct_stall || raw_stall;
    assign start = start_req && !stall;

    assign exc_result = kind_div_q ? 32'd3 : 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pwir_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            kind_div_q  <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            unique case (state_q)
                IDLE: ;
                START: begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                end
                BUSY: begin
                    if (bus.unit_rdy_i || (cnt_q == 6'd63)) begin
                        state_q <= DONE;
                        if (bus.unit_rdy_i && !bus.unit_exception_i) begin
                            result_q <= bus.unit_result_i;
                        end else begin
                            result_q       <= exc_result;
                            pwir_q[26:22]  <= 5'd30;
                        end
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    if (ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // start can only be true in IDLE or in DONE while writing back.
            if (start) begin
                state_q     <= START;
                pwir_q      <= bus.dxir_i;
                op_a_q      <= bus.operand_a_i;
                op_b_q      <= bus.operand_b_i;
                kind_div_q  <= is_div;
                ctrl_mult_q <= is_mul;
                ctrl_div_q  <= is_div;
            end
        end
    end

    assign bus.ctrl_mult_o         = ctrl_mult_q;
    assign bus.ctrl_div_o          = ctrl_div_q;
    assign bus.op_a_o              = op_a_q;
    assign bus.op_b_o              = op_b_q;
    assign bus.pwir_o              = pwir_q;
    assign bus.pending_result_o    = result_q;
    assign bus.mult_or_div_ready_o = ready;
    assign bus.stall_o             = stall;

endmodule

// File: doc/mult_div_pending_control.md
MULT_DIV_PENDING_CONTROL -- requirements
Module: multDivPendingControl

Interface
REQ-001 clock  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-003 DXIR  input  32  decode/execute instruction; op [31:27], rd [26:22], ALU op [6:2].
REQ-004 FDIR  input  32  fetch/decode instruction; used for RAW hazard checks.
REQ-005 operandA, operandB  input  32 each  DX source operand values.
REQ-006 mwWritesReg  input  1  MW stage writes the register file this cycle.
REQ-007 unitRDY, unitException  input  1 each  multdiv unit done / exception, valid together.
REQ-008 unitResult  input  32  multdiv unit result, valid when unitRDY=1.
REQ-009 ctrlMult, ctrlDiv  output  1 each  one-cycle start pulses to the multdiv unit.
REQ-010 opA, opB  output  32 each  registered operands held stable for the whole operation.
REQ-011 PWIR  output  32  pending-writeback instruction register.
REQ-012 pendingResult  output  32  value written to PWIR rd when multOrDivReady=1.
REQ-013 multOrDivReady  output  1  register-file write by the pending op this cycle.
REQ-014 stall  output  1  freeze FD/DX and insert a bubble.

Function
REQ-015 mul: DXIR op=00000 and ALU op=00110; div: op=00000 and ALU op=00111; start = mul or div, when stall=0.
REQ-016 FSM states are IDLE, START, BUSY and DONE; reset state is IDLE.
REQ-017 IDLE + start -> START on the next edge; capture DXIR into PWIR, operandA/B into opA/opB, and the kind (mul or div).
REQ-018 START lasts exactly one cycle; ctrlMult or ctrlDiv (per kind) =1 only in START; -> BUSY.
REQ-019 BUSY: clear a 6-bit cycle counter on entry and increment it each cycle; unitRDY=1 -> DONE, latching the result.
REQ-020 Result latch, no exception: pendingResult=unitResult, PWIR unchanged.
REQ-021 Result latch, exception: pendingResult = 1 for mul and 3 for div; PWIR[26:22]=11110 (r30); other PWIR bits unchanged.
REQ-022 BUSY timeout: counter reaching 63 without unitRDY -> DONE, treated as an exception per REQ-021.
REQ-023 DONE: multOrDivReady = !mwWritesReg (combinational); while mwWritesReg=1 stay in DONE and hold all values.
REQ-024 DONE with multOrDivReady=1: -> IDLE on the next edge; multOrDivReady is high for exactly one cycle per operation.
REQ-025 DONE + start in the same cycle: multOrDivReady=1 -> START directly, capturing the new op; multOrDivReady=0 -> stall.
REQ-026 Structural stall: stall=1 when start conditions hold (ignoring stall) and state is START or BUSY, or DONE without multOrDivReady.
REQ-027 RAW stall: stall=1 when state is not IDLE, PWIR rd is nonzero, and the FDIR-read register equals PWIR rd.
REQ-028 FDIR-read register: the rs and rt fields for ALU ops; rd and rs for op 00010/00110; rd for op 00111/01000.
REQ-029 RAW stall clears in the cycle multOrDivReady=1.
REQ-030 PWIR rd=0 on a non-exception op: run the full sequence; multOrDivReady still pulses, and the register file ignores r0.
REQ-031 unitRDY in IDLE or START is ignored.
REQ-032 ctrlMult and ctrlDiv are never high together.

Reset
REQ-033 reset low -> state IDLE; PWIR, opA, opB, pendingResult and counter = 0; ctrlMult, ctrlDiv, multOrDivReady and stall = 0.
REQ-034 Reset asserted mid-operation aborts it: no multOrDivReady pulse, and a unitRDY after release is ignored.
REQ-035 First start is accepted on the first rising edge after reset deasserts.

Verification
REQ-036 Mul r3=r1*r2 (A=6, B=7), unitRDY 16 cycles after START: one ctrlMult pulse; multOrDivReady=1 once, PWIR rd=3, pendingResult=42.
REQ-037 Div with unitException=1: PWIR rd=30, pendingResult=3, one multOrDivReady pulse.
REQ-038 In DONE, mwWritesReg=1 for 3 cycles: multOrDivReady=0 for 3 cycles, then 1 for one cycle; pendingResult unchanged.
REQ-039 FDIR add r4=r3+r1 while mul to r3 is BUSY: stall=1 until the multOrDivReady cycle; no stall for FDIR reading r5.
REQ-040 Second mul arrives while BUSY: stall=1, no second ctrlMult; the second op starts in the cycle after the first writes back.
REQ-041 Reset pulsed low in BUSY, then unitRDY=1: all outputs 0, multOrDivReady never asserted.
